muldiv_hilo: RTL and testbench

Multi-cycle multiply/divide unit owning the HI/LO register pair for the MIPS datapath. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and serves MFHI/MFLO reads. It extends the single-cycle ALU multiply path with three additions: parametrised width, an iterative divider, and a busy/done handshake that the hazard unit uses to stall the pipeline. It sits beside the ALU in the execute stage and is driven by the decoded funct field.

---
 rtl/muldiv_hilo.sv | 212 +++++++++++++++++++++
 tb/tb_muldiv_hilo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// Multiply uses a latency counter; divide is a radix-2 restoring divider plus a sign-fix cycle.
module muldiv_hilo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic [1:0]       hilo_sel,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hilo_rdata
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;   // multiplicand during MUL, dividend/quotient during DIV
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sgn_q, sgn_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, diff;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH-1:0] q_fix, r_fix;

  // Operand conditioning, one restoring step, and the full-width product.
  always_comb begin
    sgn_op = ~op[0];
    a_neg  = sgn_op & a[WIDTH-1];
    b_neg  = sgn_op & b[WIDTH-1];
    a_mag  = a_neg ? (~a + WIDTH'(1)) : a;
    b_mag  = b_neg ? (~b + WIDTH'(1)) : b;
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, opb_q};
    ext_a  = sgn_q ? {{WIDTH{quo_q[WIDTH-1]}}, quo_q} : {{WIDTH{1'b0}}, quo_q};
    ext_b  = sgn_q ? {{WIDTH{opb_q[WIDTH-1]}}, opb_q} : {{WIDTH{1'b0}}, opb_q};
    prod   = ext_a * ext_b;
    q_fix  = qneg_q ? (~quo_q + WIDTH'(1)) : quo_q;
    r_fix  = rneg_q ? (~rem_q + WIDTH'(1)) : rem_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              quo_d   = a;
              opb_d   = b;
              sgn_d   = sgn_op;
              cnt_d   = CW'(MUL_CYCLES - 1);
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              quo_d   = a_mag;
              opb_d   = b_mag;
              rem_d   = '0;
              qneg_d  = a_neg ^ b_neg;
              rneg_d  = a_neg;
              zero_d  = (b == '0);
              cnt_d   = CW'(WIDTH - 1);
              state_d = (b == '0) ? S_FIX : S_DIV;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          hi_d    = prod[2*WIDTH-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DIV: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FIX: begin
        done_d  = 1'b1;
        dbz_d   = zero_q;
        state_d = S_IDLE;
        if (!zero_q) begin
          lo_d = q_fix;
          hi_d = r_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Squash wins over accept and completion: nothing is written or signalled.
    if (flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    case (hilo_sel)
      2'b00:   hilo_rdata = lo_q;
      2'b01:   hilo_rdata = hi_q;
      default: hilo_rdata = '0;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: expected HI/LO are queued at issue and checked on done.
module tb_muldiv_hilo;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst, start, flush;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic [1:0]    hilo_sel;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo, hilo_rdata;

  muldiv_hilo #(.WIDTH(W), .MUL_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hilo_sel(hilo_sel), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo), .hilo_rdata(hilo_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] m_hi, m_lo;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: updates the architectural HI/LO copy and queues completions.
  task automatic push_model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint       sx, sy;
    logic [63:0]  ux, uy, p, q, r;
    exp_t         e;
    logic         dbz;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = {32'b0, x};
    uy  = {32'b0, y};
    dbz = 1'b0;
    case (o)
      3'd0: begin p = 64'(sx * sy); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = ux * uy;      m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2, 3'd3: begin
        if (y == '0) begin
          dbz = 1'b1;
        end else if (o == 3'd2) begin
          q = 64'(sx / sy); r = 64'(sx % sy);
          m_lo = q[31:0]; m_hi = r[31:0];
        end else begin
          q = ux / uy; r = ux % uy;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
    if (o <= 3'd3) begin
      e = '{hi: m_hi, lo: m_lo, dbz: dbz};
      sb_q.push_back(e);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit track);
    op = o; a = x; b = y; start = 1'b1;
    if (track) push_model(o, x, y);
    cycle();
    start = 1'b0;
  endtask

  // n0 = edges already elapsed since the accept edge.
  task automatic wait_done(input string tag, input int exp_lat, input int n0);
    int n;
    n = n0;
    while (done !== 1'b1 && n < 200) begin
      cycle();
      n++;
    end
    check_val({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check_val({tag, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  // Completion monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_done", 64'(done), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("sb_hi", 64'(hi), 64'(mon_e.hi));
        check_val("sb_lo", 64'(lo), 64'(mon_e.lo));
        check_val("sb_dbz", 64'(div_by_zero), 64'(mon_e.dbz));
      end
    end else if (div_by_zero === 1'b1) begin
      check_val("dbz_without_done", 64'(div_by_zero), 64'(done));
    end
  end

  initial begin
    int           lat;
    logic [2:0]   ro;
    logic [W-1:0] rx, ry;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; hilo_sel = 2'b00;
    m_hi = '0; m_lo = '0;
    repeat (2) cycle();
    check_val("rst_hi", 64'(hi), 64'd0);
    check_val("rst_lo", 64'(lo), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    cycle();

    // Multiply, then two back-to-back issues in the done cycle.
    issue(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b1);
    check_val("mult_busy1", 64'(busy), 64'd1);
    cycle();
    check_val("mult_busy2", 64'(busy), 64'd1);
    wait_done("mult", 2, 1);
    check_val("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check_val("mult_lo", 64'(lo), 64'hFFFF_FFFE);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_done("multu", 2, 0);
    check_val("multu_hi", 64'(hi), 64'h0000_0001);
    check_val("multu_lo", 64'(lo), 64'hFFFF_FFFE);
    issue(3'd0, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
    wait_done("b2b_mult", 2, 0);

    // Divides, including overflow and divide-by-zero.
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("div", W + 1, 0);
    check_val("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check_val("div_hi", 64'(hi), 64'hFFFF_FFFF);
    issue(3'd3, 32'd100, 32'd7, 1'b1);
    wait_done("divu", W + 1, 0);
    check_val("divu_lo", 64'(lo), 64'd14);
    check_val("divu_hi", 64'(hi), 64'd2);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("div_ovf", W + 1, 0);
    check_val("div_ovf_lo", 64'(lo), 64'h8000_0000);
    check_val("div_ovf_hi", 64'(hi), 64'd0);
    check_val("div_ovf_dbz", 64'(div_by_zero), 64'd0);
    issue(3'd3, 32'd5, 32'd0, 1'b1);
    wait_done("divu0", 1, 0);
    check_val("divu0_dbz", 64'(div_by_zero), 64'd1);
    check_val("divu0_hi", 64'(hi), 64'd0);
    check_val("divu0_lo", 64'(lo), 64'h8000_0000);

    // Flush mid-divide: no completion, registers untouched.
    issue(3'd2, 32'd1000, 32'd7, 1'b0);
    repeat (9) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check_val("flush_busy", 64'(busy), 64'd0);
    check_val("flush_done", 64'(done), 64'd0);
    check_val("flush_hi", 64'(hi), 64'(m_hi));
    check_val("flush_lo", 64'(lo), 64'(m_lo));
    repeat (40) cycle();

    // Start while busy is ignored.
    issue(3'd2, 32'hFFFF_FC18, 32'd7, 1'b1);
    repeat (4) cycle();
    op = 3'd1; a = 32'd9; b = 32'd9; start = 1'b1;
    cycle();
    start = 1'b0;
    wait_done("busy_start", W + 1, 5);
    check_val("busy_start_lo", 64'(lo), 64'hFFFF_FF72);
    check_val("busy_start_hi", 64'(hi), 64'hFFFF_FFFA);
    repeat (3) cycle();
    check_val("busy_start_idle", 64'(busy), 64'd0);

    // Flush on the completing multiply edge suppresses the write.
    issue(3'd0, 32'd3, 32'd5, 1'b0);
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check_val("flush_cmp_done", 64'(done), 64'd0);
    check_val("flush_cmp_hi", 64'(hi), 64'(m_hi));
    check_val("flush_cmp_lo", 64'(lo), 64'(m_lo));
    check_val("flush_cmp_busy", 64'(busy), 64'd0);

    // Move-to and read-back mux.
    issue(3'd4, 32'h0000_1234, 32'd0, 1'b1);
    check_val("mthi_busy", 64'(busy), 64'd0);
    check_val("mthi_hi", 64'(hi), 64'h1234);
    hilo_sel = 2'b01; #1;
    check_val("rdata_hi", 64'(hilo_rdata), 64'h1234);
    hilo_sel = 2'b10; #1;
    check_val("rdata_none", 64'(hilo_rdata), 64'd0);
    hilo_sel = 2'b00; #1;
    check_val("rdata_lo", 64'(hilo_rdata), 64'(m_lo));
    cycle();
    check_val("mthi_busy2", 64'(busy), 64'd0);
    issue(3'd5, 32'h0000_ABCD, 32'd0, 1'b1);
    check_val("mtlo_lo", 64'(lo), 64'hABCD);
    hilo_sel = 2'b11; #1;
    check_val("rdata_none11", 64'(hilo_rdata), 64'd0);
    issue(3'd6, 32'h5555_5555, 32'h5555_5555, 1'b0);
    check_val("op6_busy", 64'(busy), 64'd0);
    check_val("op6_hi", 64'(hi), 64'h1234);
    check_val("op6_lo", 64'(lo), 64'hABCD);

    // Random mix of multiplies and divides.
    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i == 4) ? 32'd0 : $urandom;
      if (i == 7) ry = 32'hFFFF_FFFF;
      if (i == 8) ry = 32'd1;
      lat = (ro < 3'd2) ? 2 : ((ry == '0) ? 1 : W + 1);
      issue(ro, rx, ry, 1'b1);
      wait_done("rnd", lat, 0);
    end

    // Reset mid-divide discards the op and clears everything.
    issue(3'd2, 32'd1000, 32'd7, 1'b0);
    repeat (4) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    check_val("rst_mid_hi", 64'(hi), 64'd0);
    check_val("rst_mid_lo", 64'(lo), 64'd0);
    check_val("rst_mid_busy", 64'(busy), 64'd0);
    check_val("rst_mid_done", 64'(done), 64'd0);
    check_val("rst_mid_dbz", 64'(div_by_zero), 64'd0);
    repeat (40) cycle();
    check_val("rst_mid_idle", 64'(busy), 64'd0);

    check_val("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
